// File: rtl/not_chk_pkg.sv
// Shared types and helpers for the not_gate response checker.
package not_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMPARE
  } chk_state_t;

  // Expected response for one bit: inverting cell when invert=1, buffer otherwise.
  function automatic logic exp_resp(input logic stim, input logic invert);
    return stim ^ invert;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/not_gate_resp_checker.sv
// Response checker for the not_gate cell: accept a vector, settle, compare, count.
// Optional first-failure capture is enabled by defining NOT_CHK_FAIL_CAPTURE_EN.
module not_gate_resp_checker
  import not_chk_pkg::*;
#(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8,
  parameter bit          INVERT        = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stim_valid_i,
  output logic             stim_ready_o,
  input  logic [WIDTH-1:0] stim_data_i,
  input  logic [WIDTH-1:0] resp_data_i,
  input  logic             clear_i,
  output logic             cmp_valid_o,
  output logic             cmp_pass_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             any_fail_o,
  output logic [WIDTH-1:0] fail_stim_o,
  output logic [WIDTH-1:0] fail_resp_o
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  chk_state_t         state_q, state_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0]   stim_q, stim_d;
  logic [WIDTH-1:0]   expected;
  logic               cmp_valid_q, cmp_pass_q, any_fail_q;
  logic               accept, do_cmp, mismatch;

  assign stim_ready_o = (state_q == IDLE);
  assign accept       = stim_valid_i && stim_ready_o;
  assign do_cmp       = (state_q == COMPARE);
  assign mismatch     = (resp_data_i != expected);

  always_comb begin
    expected = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      expected[i] = exp_resp(stim_q[i], INVERT);
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    stim_d       = stim_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stim_d       = stim_data_i;
          settle_cnt_d = SettleW'(SETTLE_CYCLES - 1);
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = COMPARE;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      COMPARE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      stim_q       <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_pass_q   <= 1'b0;
      any_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      stim_q       <= stim_d;
      cmp_valid_q  <= do_cmp;
      if (do_cmp) begin
        cmp_pass_q <= !mismatch;
      end
      // clear overrides a same-edge mismatch; the pulse itself is unaffected
      if (clear_i) begin
        any_fail_q <= 1'b0;
      end else if (do_cmp && mismatch) begin
        any_fail_q <= 1'b1;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_vec_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(do_cmp),
    .clr_i(clear_i),
    .cnt_o(vec_cnt_o)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(do_cmp && mismatch),
    .clr_i(clear_i),
    .cnt_o(err_cnt_o)
  );

`ifdef NOT_CHK_FAIL_CAPTURE_EN
  logic [WIDTH-1:0] fail_stim_q, fail_resp_q;

  // Only the first mismatch since reset/clear is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_stim_q <= '0;
      fail_resp_q <= '0;
    end else if (clear_i) begin
      fail_stim_q <= '0;
      fail_resp_q <= '0;
    end else if (do_cmp && mismatch && !any_fail_q) begin
      fail_stim_q <= stim_q;
      fail_resp_q <= resp_data_i;
    end
  end

  assign fail_stim_o = fail_stim_q;
  assign fail_resp_o = fail_resp_q;
`else
  assign fail_stim_o = '0;
  assign fail_resp_o = '0;
`endif

  assign cmp_valid_o = cmp_valid_q;
  assign cmp_pass_o  = cmp_pass_q;
  assign any_fail_o  = any_fail_q;

endmodule
